// File: rtl/mod10_stopwatch_ctrl_if.sv
// rtl/mod10_stopwatch_ctrl_if.sv - button inputs and display/status outputs of the stopwatch controller
interface mod10_stopwatch_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    start_stop;
   logic                    clear;
   logic                    lap;
   logic [4*NUM_DIGITS-1:0] digits;
   logic [4*NUM_DIGITS-1:0] disp;
   logic                    running;
   logic                    lap_hold;
   logic                    tick;
   logic                    overflow;

   // button/synchroniser side
   modport master (
      output start_stop, clear, lap,
      input  digits, disp, running, lap_hold, tick, overflow
   );

   // stopwatch controller side
   modport slave (
      input  start_stop, clear, lap,
      output digits, disp, running, lap_hold, tick, overflow
   );
endinterface

// File: rtl/mod10_stopwatch_ctrl.sv
// rtl/mod10_stopwatch_ctrl.sv - BCD stopwatch: prescaler, run/pause FSM, decade cascade, lap freeze
module mod10_stopwatch_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int TICK_DIV   = 10
) (
   input logic                   clk,
   input logic                   reset,
   mod10_stopwatch_ctrl_if.slave bus
);
   localparam int              PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int              DW         = 4*NUM_DIGITS;
   localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV-1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic            ss_prev, clr_prev, lap_prev;
   logic            clr_ev, ss_ev, lap_ev;
   logic [PW-1:0]   presc, presc_nxt;
   logic [DW-1:0]   digits_q, digits_nxt;
   logic [DW-1:0]   snap_q, snap_nxt;
   logic [DW-1:0]   digits_inc;
   logic            lap_hold_q, lap_hold_nxt;
   logic            ovf_q, ovf_nxt;
   logic            tick;
   logic            wrap;

   // Rising-edge events, masked so only the highest-priority one survives (clear > start_stop > lap)
   always_comb begin
      clr_ev = bus.clear & ~clr_prev;
      ss_ev  = bus.start_stop & ~ss_prev & ~clr_ev;
      lap_ev = bus.lap & ~lap_prev & ~clr_ev & ~ss_ev;
   end

   assign tick = (state == ST_RUN) && (presc == PRESC_LAST);

   // Decade cascade: digit k advances when tick is high and every lower digit is 9, resolved in one cycle
   always_comb begin
      logic all9;
      digits_inc = digits_q;
      all9       = tick;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (all9) begin
            digits_inc[4*k +: 4] = (digits_q[4*k +: 4] == 4'd9) ? 4'd0 : digits_q[4*k +: 4] + 4'd1;
         end
         all9 = all9 && (digits_q[4*k +: 4] == 4'd9);
      end
      wrap = all9;
   end

   // Run/pause sequencing; clear returns to IDLE from any state
   always_comb begin
      state_nxt = state;
      if (clr_ev) begin
         state_nxt = ST_IDLE;
      end else if (ss_ev) begin
         case (state)
            ST_IDLE:  state_nxt = ST_RUN;
            ST_RUN:   state_nxt = ST_PAUSE;
            ST_PAUSE: state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   // Prescaler, digits, lap snapshot and sticky overflow next values
   always_comb begin
      presc_nxt    = presc;
      digits_nxt   = digits_q;
      snap_nxt     = snap_q;
      lap_hold_nxt = lap_hold_q;
      ovf_nxt      = ovf_q;
      if (clr_ev) begin
         presc_nxt    = '0;
         digits_nxt   = '0;
         snap_nxt     = '0;
         lap_hold_nxt = 1'b0;
         ovf_nxt      = 1'b0;
      end else begin
         // a tick on the same edge as a pause request is still counted
         digits_nxt = digits_inc;
         if (wrap) begin
            ovf_nxt = 1'b1;
         end
         case (state)
            ST_RUN: begin
               presc_nxt = (presc == PRESC_LAST) ? '0 : presc + 1'b1;
               if (lap_ev) begin
                  if (lap_hold_q) begin
                     lap_hold_nxt = 1'b0;
                  end else begin
                     lap_hold_nxt = 1'b1;
                     snap_nxt     = digits_q;
                  end
               end
            end
            ST_PAUSE: begin
               // paused: prescaler holds so resume finishes the partial interval; lap only releases
               if (lap_ev) begin
                  lap_hold_nxt = 1'b0;
               end
            end
            default: begin
               presc_nxt = '0;
            end
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Datapath and edge-detect history registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ss_prev    <= 1'b0;
         clr_prev   <= 1'b0;
         lap_prev   <= 1'b0;
         presc      <= '0;
         digits_q   <= '0;
         snap_q     <= '0;
         lap_hold_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         ss_prev    <= bus.start_stop;
         clr_prev   <= bus.clear;
         lap_prev   <= bus.lap;
         presc      <= presc_nxt;
         digits_q   <= digits_nxt;
         snap_q     <= snap_nxt;
         lap_hold_q <= lap_hold_nxt;
         ovf_q      <= ovf_nxt;
      end
   end

   assign bus.digits   = digits_q;
   assign bus.disp     = lap_hold_q ? snap_q : digits_q;
   assign bus.running  = (state == ST_RUN);
   assign bus.lap_hold = lap_hold_q;
   assign bus.tick     = tick;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_mod10_stopwatch_ctrl.sv
// tb/tb_mod10_stopwatch_ctrl.sv - self-checking bench for mod10_stopwatch_ctrl
module tb_mod10_stopwatch_ctrl;
   localparam int ND  = 4;
   localparam int TD  = 10;
   localparam int SND = 2;
   localparam int STD = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   mod10_stopwatch_ctrl_if #(.NUM_DIGITS(ND))  bif ();
   mod10_stopwatch_ctrl_if #(.NUM_DIGITS(SND)) sif ();

   mod10_stopwatch_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.slave)
   );

   mod10_stopwatch_ctrl #(.NUM_DIGITS(SND), .TICK_DIV(STD)) dut_small (
      .clk   (clk),
      .reset (reset),
      .bus   (sif.slave)
   );

   always #5 clk = ~clk;

   // reference model: integer count, mode 0=idle 1=run 2=pause
   int m_mode, m_presc, m_count, m_snap;
   bit m_lh, m_ovf, m_pss, m_pclr, m_plap;

   logic [35:0] obs;
   assign obs = {bif.digits, bif.disp, bif.running, bif.lap_hold, bif.tick, bif.overflow};

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int d;
      d = 1;
      for (int k = 0; k < 4; k++) begin
         r[4*k +: 4] = 4'((v / d) % 10);
         d = d * 10;
      end
      return r;
   endfunction

   function automatic logic [35:0] exp_vec();
      logic [15:0] dg, dp;
      dg = to_bcd(m_count);
      dp = m_lh ? to_bcd(m_snap) : dg;
      return {dg, dp, (m_mode == 1), m_lh, ((m_mode == 1) && (m_presc == TD-1)), m_ovf};
   endfunction

   task automatic model_reset();
      m_mode = 0; m_presc = 0; m_count = 0; m_snap = 0;
      m_lh = 0; m_ovf = 0; m_pss = 0; m_pclr = 0; m_plap = 0;
   endtask

   task automatic model_update();
      bit ce, se, le, tk;
      int old;
      ce  = bif.clear && !m_pclr;
      se  = bif.start_stop && !m_pss && !ce;
      le  = bif.lap && !m_plap && !ce && !se;
      tk  = (m_mode == 1) && (m_presc == TD-1);
      old = m_count;
      if (ce) begin
         m_mode = 0; m_presc = 0; m_count = 0; m_snap = 0; m_lh = 0; m_ovf = 0;
      end else begin
         if (tk) begin
            m_count = (m_count + 1) % 10000;
            if (m_count == 0) m_ovf = 1;
         end
         if (m_mode == 1) begin
            m_presc = (m_presc + 1) % TD;
            if (le) begin
               if (m_lh) m_lh = 0;
               else begin
                  m_lh = 1;
                  m_snap = old;
               end
            end
         end else if (m_mode == 2) begin
            if (le) m_lh = 0;
         end else begin
            m_presc = 0;
         end
         if (se) m_mode = (m_mode == 1) ? 2 : 1;
      end
      m_pss  = bif.start_stop;
      m_pclr = bif.clear;
      m_plap = bif.lap;
   endtask

   task automatic step();
      @(posedge clk);
      if (reset) model_update();
      else model_reset();
      #1;
   endtask

   task automatic test_reset();
      bif.start_stop = 0; bif.clear = 0; bif.lap = 0;
      sif.start_stop = 0; sif.clear = 0; sif.lap = 0;
      #1 reset = 0;
      #2;
      model_reset();
      n_checks++;
      if (obs !== 36'h0) $display("FAIL reset_async got %h want 0", obs);
      else n_pass++;
      n_checks++;
      if ({sif.digits, sif.disp, sif.running, sif.lap_hold, sif.tick, sif.overflow} !== 20'h0)
         $display("FAIL reset_small got %h/%b want 0", sif.digits, sif.overflow);
      else n_pass++;
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1;
      step();
      n_checks++;
      if (obs !== exp_vec() || bif.running !== 1'b0) $display("FAIL reset_idle got %h want %h", obs, exp_vec());
      else n_pass++;
   endtask

   task automatic test_start_tick();
      int first_tick;
      bit run_ok;
      first_tick = -1;
      run_ok = 1;
      bif.start_stop = 1;
      step();
      bif.start_stop = 0;
      for (int j = 1; j <= 100; j++) begin
         step();
         if (bif.tick === 1'b1 && first_tick < 0) first_tick = j;
         if (bif.running !== 1'b1) run_ok = 0;
         if (j == 10) begin
            n_checks++;
            if (bif.digits !== 16'h0001) $display("FAIL start_digit1 got %h want 0001", bif.digits);
            else n_pass++;
         end
      end
      n_checks++;
      if (first_tick != 9) $display("FAIL first_tick got cycle %0d want 9", first_tick);
      else n_pass++;
      n_checks++;
      if (bif.digits !== 16'h0010) $display("FAIL start_digit10 got %h want 0010", bif.digits);
      else n_pass++;
      n_checks++;
      if (!run_ok) $display("FAIL start_running got dropout want always 1");
      else n_pass++;
   endtask

   task automatic test_pause_resume();
      int n;
      bit hold_ok;
      bif.clear = 1; step(); bif.clear = 0;
      bif.start_stop = 1; step(); bif.start_stop = 0;
      for (n = 0; n < 300 && !(m_count == 9 && m_presc == 3); n++) step();
      n_checks++;
      if (n == 300) $display("FAIL pause_reach9 got timeout want count 9");
      else n_pass++;
      bif.start_stop = 1; step(); bif.start_stop = 0;
      hold_ok = 1;
      for (int j = 0; j < 25; j++) begin
         step();
         if (bif.digits !== 16'h0009 || bif.running !== 1'b0 || bif.tick !== 1'b0) hold_ok = 0;
      end
      n_checks++;
      if (!hold_ok) $display("FAIL pause_hold got %h want 0009 held", bif.digits);
      else n_pass++;
      bif.start_stop = 1; step(); bif.start_stop = 0;
      for (n = 1; n <= 20; n++) begin
         step();
         if (bif.digits === 16'h0010) break;
      end
      n_checks++;
      if (n != 6) $display("FAIL resume_latency got %0d want 6", n);
      else n_pass++;
   endtask

   task automatic test_overflow();
      sif.clear = 1; step(); sif.clear = 0;
      sif.start_stop = 1; step(); sif.start_stop = 0;
      repeat (199) step();
      n_checks++;
      if (sif.digits !== 8'h99 || sif.overflow !== 1'b0)
         $display("FAIL ovf_pre got %h/%b want 99/0", sif.digits, sif.overflow);
      else n_pass++;
      step();
      n_checks++;
      if (sif.digits !== 8'h00 || sif.overflow !== 1'b1 || sif.running !== 1'b1)
         $display("FAIL ovf_wrap got %h/%b want 00/1", sif.digits, sif.overflow);
      else n_pass++;
      repeat (5) step();
      n_checks++;
      if (sif.overflow !== 1'b1 || sif.digits !== 8'h02) $display("FAIL ovf_sticky got %h/%b want 02/1", sif.digits, sif.overflow);
      else n_pass++;
      sif.clear = 1; step(); sif.clear = 0;
      n_checks++;
      if (sif.digits !== 8'h00 || sif.overflow !== 1'b0 || sif.running !== 1'b0 || sif.tick !== 1'b0)
         $display("FAIL ovf_clear got %h/%b/%b want 00/0/0", sif.digits, sif.overflow, sif.running);
      else n_pass++;
   endtask

   task automatic test_lap();
      int n;
      bit frz_ok;
      bif.clear = 1; step(); bif.clear = 0;
      bif.start_stop = 1; step(); bif.start_stop = 0;
      for (n = 0; n < 600 && m_count != 42; n++) step();
      bif.lap = 1; step(); bif.lap = 0;
      n_checks++;
      if (bif.disp !== 16'h0042 || bif.lap_hold !== 1'b1) $display("FAIL lap_capture got %h/%b want 0042/1", bif.disp, bif.lap_hold);
      else n_pass++;
      frz_ok = 1;
      for (int j = 0; j < 30; j++) begin
         step();
         if (bif.disp !== 16'h0042 || bif.digits !== to_bcd(m_count)) frz_ok = 0;
      end
      n_checks++;
      if (!frz_ok || bif.digits !== 16'h0045) $display("FAIL lap_freeze got disp %h digits %h want 0042/0045", bif.disp, bif.digits);
      else n_pass++;
      bif.start_stop = 1; step(); bif.start_stop = 0;
      bif.lap = 1; step(); bif.lap = 0;
      n_checks++;
      if (bif.lap_hold !== 1'b0 || bif.disp !== bif.digits || obs !== exp_vec())
         $display("FAIL lap_release got %h want %h", obs, exp_vec());
      else n_pass++;
   endtask

   task automatic test_priority();
      int trans;
      logic prev_run;
      bif.clear = 1; step(); bif.clear = 0;
      bif.start_stop = 1; step(); bif.start_stop = 0;
      repeat (15) step();
      bif.start_stop = 1; bif.clear = 1; step(); bif.start_stop = 0; bif.clear = 0;
      n_checks++;
      if (bif.running !== 1'b0 || bif.digits !== 16'h0 || obs !== exp_vec())
         $display("FAIL prio_clear got %h want %h", obs, exp_vec());
      else n_pass++;
      step();
      trans = 0;
      prev_run = bif.running;
      bif.start_stop = 1;
      for (int j = 0; j < 50; j++) begin
         step();
         if (bif.running !== prev_run) trans++;
         prev_run = bif.running;
      end
      bif.start_stop = 0;
      n_checks++;
      if (trans != 1 || bif.running !== 1'b1) $display("FAIL held_button got %0d transitions want 1", trans);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      int n;
      bif.clear = 1; step(); bif.clear = 0;
      bif.start_stop = 1; step(); bif.start_stop = 0;
      for (n = 0; n < 1500 && m_count != 120; n++) step();
      bif.lap = 1; step(); bif.lap = 0;
      for (n = 0; n < 400 && m_count != 137; n++) step();
      n_checks++;
      if (bif.digits !== 16'h0137 || bif.lap_hold !== 1'b1) $display("FAIL areset_pre got %h/%b want 0137/1", bif.digits, bif.lap_hold);
      else n_pass++;
      #2 reset = 0;
      #1;
      model_reset();
      n_checks++;
      if (obs !== 36'h0) $display("FAIL areset_now got %h want 0", obs);
      else n_pass++;
      @(negedge clk) reset = 1;
      repeat (20) step();
      n_checks++;
      if (bif.running !== 1'b0 || bif.digits !== 16'h0 || bif.tick !== 1'b0) $display("FAIL areset_idle got %h/%b want 0000/0", bif.digits, bif.running);
      else n_pass++;
      bif.start_stop = 1; step(); bif.start_stop = 0;
      n_checks++;
      if (bif.running !== 1'b1) $display("FAIL areset_restart got %b want 1", bif.running);
      else n_pass++;
   endtask

   task automatic test_random();
      int errs;
      logic [35:0] bad_got, bad_exp;
      errs = 0;
      bad_got = '0;
      bad_exp = '0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) bif.start_stop = ~bif.start_stop;
         if ($urandom_range(0, 5) == 0) bif.lap = ~bif.lap;
         bif.clear = ($urandom_range(0, 299) == 0);
         step();
         if (obs !== exp_vec()) begin
            if (errs == 0) begin
               bad_got = obs;
               bad_exp = exp_vec();
            end
            errs++;
         end
      end
      bif.start_stop = 0; bif.lap = 0; bif.clear = 0;
      n_checks++;
      if (errs != 0) $display("FAIL random_model got %0d mismatches (first %h want %h) want 0", errs, bad_got, bad_exp);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_start_tick();
      test_pause_resume();
      test_overflow();
      test_lap();
      test_priority();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
